// File: rtl/bit_copy_seq.sv
// Bit-serial copier: latches a source vector, then writes it into the working register one bit
// per clock, LSB first. Optional simulation trace when BIT_COPY_TRACE_EN is defined.
module bit_copy_seq #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             step_valid,
    output logic [IW-1:0]    step_idx,
    output logic             step_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       done_count
);

    typedef enum logic [1:0] {StIdle, StCopy, StDone} state_e;

    localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             in_ready_q, in_ready_d;
    logic             step_valid_q, step_valid_d;
    logic [IW-1:0]    step_idx_q, step_idx_d;
    logic             step_bit_q, step_bit_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       done_count_q, done_count_d;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        work_d       = work_q;
        idx_d        = idx_q;
        step_valid_d = 1'b0;
        step_idx_d   = step_idx_q;
        step_bit_d   = step_bit_q;
        out_valid_d  = out_valid_q;
        done_count_d = done_count_q;

        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            idx_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready_q) begin
                        shadow_d = in_data;
                        idx_d    = '0;
                        state_d  = StCopy;
                    end
                end
                StCopy: begin
                    // Only the indexed bit changes; the rest keeps the previous vector.
                    work_d[idx_q] = shadow_q[idx_q];
                    step_valid_d  = 1'b1;
                    step_idx_d    = idx_q;
                    step_bit_d    = shadow_q[idx_q];
                    if (idx_q == LastIdx) begin
                        idx_d        = '0;
                        state_d      = StDone;
                        out_valid_d  = 1'b1;
                        done_count_d = done_count_q + 8'd1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Registered so in_ready stays low through reset and rises one edge after it.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shadow_q     <= '0;
            work_q       <= '0;
            idx_q        <= '0;
            in_ready_q   <= 1'b0;
            step_valid_q <= 1'b0;
            step_idx_q   <= '0;
            step_bit_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            work_q       <= work_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            step_valid_q <= step_valid_d;
            step_idx_q   <= step_idx_d;
            step_bit_q   <= step_bit_d;
            out_valid_q  <= out_valid_d;
            done_count_q <= done_count_d;
        end
    end

`ifdef BIT_COPY_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst_n && !flush && state_q == StCopy) begin
            $display("copy : %0d %b", idx_q, work_d);
            if (idx_q == LastIdx) begin
                $display("copy : done %b", work_d);
            end
        end
    end
`endif

    assign in_ready   = in_ready_q;
    assign step_valid = step_valid_q;
    assign step_idx   = step_idx_q;
    assign step_bit   = step_bit_q;
    assign out_valid  = out_valid_q;
    assign out_data   = work_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_bit_copy_seq.sv
// Directed self-checking bench for bit_copy_seq at WIDTH=4.
module tb_bit_copy_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       flush;
    logic       step_valid;
    logic [1:0] step_idx;
    logic       step_bit;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [7:0] done_count;

    int total;
    int bad;

    bit_copy_seq #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .flush      (flush),
        .step_valid (step_valid),
        .step_idx   (step_idx),
        .step_bit   (step_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [17:0] obs;
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'b1111; flush = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            obs = {in_ready, step_valid, step_idx, step_bit, out_valid, out_data, done_count};
            total++;
            if (obs !== 18'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got %b expected all zero", c, obs);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || out_data !== 4'b0000 || done_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_release: in_ready=%b out_data=%b done_count=%0d expected 1 0000 0",
                     in_ready, out_data, done_count);
        end
        tick();
        total++;
        if (step_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_no_accept: step_valid=%b in_ready=%b expected 0 1",
                     step_valid, in_ready);
        end
    endtask

    task automatic test_first_vector();
        logic [3:0] vec;
        logic [3:0] part [4];
        vec = 4'b0101;
        part[0] = 4'b0001; part[1] = 4'b0001; part[2] = 4'b0101; part[3] = 4'b0101;
        in_valid = 1'b1; in_data = vec;
        tick();
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || step_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_accept: in_ready=%b step_valid=%b expected 0 0", in_ready, step_valid);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (step_valid !== 1'b1 || step_idx !== 2'(k) || step_bit !== vec[k] ||
                out_data !== part[k] || out_valid !== (k == 3)) begin
                bad++;
                $display("FAIL first_step%0d: got v=%b i=%0d b=%b d=%b ov=%b expected 1 %0d %b %b %b",
                         k, step_valid, step_idx, step_bit, out_data, out_valid, k, vec[k], part[k],
                         k == 3);
            end
        end
        total++;
        if (done_count !== 8'd1) begin
            bad++;
            $display("FAIL first_count: got %0d expected 1", done_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || step_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_handshake: ov=%b in_ready=%b sv=%b expected 0 1 0",
                     out_valid, in_ready, step_valid);
        end
    endtask

    // Leaves the block in DONE for the back-pressure test.
    task automatic test_second_vector();
        logic [3:0] vec;
        logic [3:0] part [4];
        vec = 4'b0110;
        part[0] = 4'b0100; part[1] = 4'b0110; part[2] = 4'b0110; part[3] = 4'b0110;
        in_valid = 1'b1; in_data = vec;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (step_valid !== 1'b1 || step_idx !== 2'(k) || step_bit !== vec[k] ||
                out_data !== part[k]) begin
                bad++;
                $display("FAIL second_step%0d: got v=%b i=%0d b=%b d=%b expected 1 %0d %b %b",
                         k, step_valid, step_idx, step_bit, out_data, k, vec[k], part[k]);
            end
        end
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110 || done_count !== 8'd2) begin
            bad++;
            $display("FAIL second_done: ov=%b d=%b cnt=%0d expected 1 0110 2",
                     out_valid, out_data, done_count);
        end
    endtask

    task automatic test_back_pressure();
        in_valid = 1'b1; in_data = 4'b1111; out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== 4'b0110 || in_ready !== 1'b0 ||
                step_valid !== 1'b0 || done_count !== 8'd2) begin
                bad++;
                $display("FAIL hold_cycle%0d: ov=%b d=%b rdy=%b sv=%b cnt=%0d expected 1 0110 0 0 2",
                         c, out_valid, out_data, in_ready, step_valid, done_count);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: ov=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        tick();
        total++;
        if (step_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b0110) begin
            bad++;
            $display("FAIL hold_no_accept: sv=%b rdy=%b d=%b expected 0 1 0110",
                     step_valid, in_ready, out_data);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = 4'b1001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        total++;
        if (step_valid !== 1'b1 || step_idx !== 2'd1 || out_data !== 4'b0101) begin
            bad++;
            $display("FAIL flush_pre: sv=%b i=%0d d=%b expected 1 1 0101", step_valid, step_idx, out_data);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || step_valid !== 1'b0 || in_ready !== 1'b1 ||
            out_data !== 4'b0101 || done_count !== 8'd2) begin
            bad++;
            $display("FAIL flush_abort: ov=%b sv=%b rdy=%b d=%b cnt=%0d expected 0 0 1 0101 2",
                     out_valid, step_valid, in_ready, out_data, done_count);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || step_valid !== 1'b0 || out_data !== 4'b0101) begin
                bad++;
                $display("FAIL flush_quiet%0d: ov=%b sv=%b d=%b expected 0 0 0101",
                         c, out_valid, step_valid, out_data);
            end
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 4'b1111;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        total++;
        if (in_ready !== 1'b1 || step_valid !== 1'b0 || out_data !== 4'b0101) begin
            bad++;
            $display("FAIL flush_beats_valid: rdy=%b sv=%b d=%b expected 1 0 0101",
                     in_ready, step_valid, out_data);
        end
    endtask

    task automatic test_reset_mid_copy();
        logic [17:0] obs;
        logic [3:0]  vec;
        logic [3:0]  part [4];
        in_valid = 1'b1; in_data = 4'b0011;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        obs = {in_ready, step_valid, step_idx, step_bit, out_valid, out_data, done_count};
        total++;
        if (obs !== 18'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b expected all zero", obs);
        end
        tick();
        total++;
        if (in_ready !== 1'b1 || step_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_release: rdy=%b sv=%b expected 1 0", in_ready, step_valid);
        end
        vec = 4'b1010;
        part[0] = 4'b0000; part[1] = 4'b0010; part[2] = 4'b0010; part[3] = 4'b1010;
        in_valid = 1'b1; in_data = vec;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (step_valid !== 1'b1 || step_idx !== 2'(k) || step_bit !== vec[k] ||
                out_data !== part[k] || out_valid !== (k == 3)) begin
                bad++;
                $display("FAIL fresh_step%0d: got v=%b i=%0d b=%b d=%b ov=%b expected 1 %0d %b %b %b",
                         k, step_valid, step_idx, step_bit, out_data, out_valid, k, vec[k], part[k],
                         k == 3);
            end
        end
        total++;
        if (done_count !== 8'd1) begin
            bad++;
            $display("FAIL fresh_count: got %0d expected 1", done_count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'b1010) begin
            bad++;
            $display("FAIL fresh_handshake: ov=%b rdy=%b d=%b expected 0 1 1010",
                     out_valid, in_ready, out_data);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_first_vector();
        test_second_vector();
        test_back_pressure();
        test_flush();
        test_reset_mid_copy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
